// File: rtl/bht_update_scheduler.sv
// -----------------------------------------------------------------------------
// bht_update_scheduler
//
// Buffers resolved branches from execute and turns each one into a
// read-modify-write of the branch table's 2-bit saturating counter. The table
// has one shared read port and one write port. Fetch lookups have priority on
// the read port. A starvation counter hands the port to the updater once it has
// been blocked for STARVE_LIMIT cycles. A flush request sweeps the whole table
// invalid, one entry per cycle.
//
// Ports
//   clk, reset                    clock, asynchronous active-high reset
//   ex_valid/ex_pc/ex_target/
//   ex_taken, ex_ready            resolved-branch push interface
//   f_req, f_pc, f_grant, f_stall fetch read-port request and arbitration
//   rd_en, rd_idx                 table read strobe and index
//   rd_valid, rd_tag, rd_ctr      table read data, one cycle after rd_en
//   wr_en, wr_idx, wr_tag,
//   wr_target, wr_valid, wr_ctr   table write port
//   flush_req                     pulse that requests a full-table invalidate
//   flush_busy                    invalidate sweep in progress
//   busy                          FSM active or updates still queued
// -----------------------------------------------------------------------------
module bht_update_scheduler #(
   parameter int DEPTH        = 4,    // power of 2, at least 2
   parameter int IDX_W        = 7,
   parameter int ENTRIES      = 128,  // 2**IDX_W
   parameter int STARVE_LIMIT = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ex_valid,
   input  logic [31:0]      ex_pc,
   input  logic [31:0]      ex_target,
   input  logic             ex_taken,
   output logic             ex_ready,
   input  logic             f_req,
   input  logic [31:0]      f_pc,
   output logic             f_grant,
   output logic             f_stall,
   output logic             rd_en,
   output logic [IDX_W-1:0] rd_idx,
   input  logic             rd_valid,
   input  logic [31:0]      rd_tag,
   input  logic [1:0]       rd_ctr,
   output logic             wr_en,
   output logic [IDX_W-1:0] wr_idx,
   output logic [31:0]      wr_tag,
   output logic [31:0]      wr_target,
   output logic             wr_valid,
   output logic [1:0]       wr_ctr,
   input  logic             flush_req,
   output logic             flush_busy,
   output logic             busy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
   localparam logic [SC_W-1:0]  STARVE_AT = SC_W'(STARVE_LIMIT);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(ENTRIES - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_RD_REQ  = 3'd1;
   localparam logic [2:0] S_WAIT_RD = 3'd2;
   localparam logic [2:0] S_WRITE   = 3'd3;
   localparam logic [2:0] S_FLUSH   = 3'd4;

   logic [2:0]       state, state_nxt;
   logic [31:0]      fifo_pc     [DEPTH];
   logic [31:0]      fifo_target [DEPTH];
   logic             fifo_taken  [DEPTH];
   logic [PTR_W-1:0] head, tail;
   logic [CNT_W-1:0] count, count_step;
   logic [SC_W-1:0]  starve_cnt;
   logic             flush_pend;
   logic [IDX_W-1:0] sweep;
   logic [1:0]       ctr_q, ctr_calc;
   logic [31:0]      head_pc;
   logic             push, pop, upd_win, flush_entry, hit;
   logic             unused_f_pc_hi;

   assign unused_f_pc_hi = ^f_pc[31:IDX_W];

   assign head_pc    = fifo_pc[head];
   assign ex_ready   = (count < FULL_CNT) && (state != S_FLUSH);
   assign push       = ex_valid && ex_ready;
   assign pop        = (state == S_WRITE);
   assign count_step = count + CNT_W'(push) - CNT_W'(pop);

   // A pending flush keeps the updater off the read port: the head entry is
   // about to be discarded, so reading for it would be wasted.
   assign upd_win = (state == S_RD_REQ) && !flush_pend &&
                    (!f_req || starve_cnt == STARVE_AT);

   assign flush_entry = (state != S_FLUSH) && (state_nxt == S_FLUSH);

   // Next-state logic.
   always_comb begin
      // NOTE: every combinational output gets a default before the case so no
      // path leaves it unassigned, which would infer a latch.
      state_nxt = state;
      unique case (state)
         S_IDLE:    if (flush_pend) state_nxt = S_FLUSH;
                    else if (count != '0) state_nxt = S_RD_REQ;
         S_RD_REQ:  if (flush_pend) state_nxt = S_FLUSH;
                    else if (upd_win) state_nxt = S_WAIT_RD;
         S_WAIT_RD: state_nxt = S_WRITE;
         S_WRITE:   if (flush_pend) state_nxt = S_FLUSH;
                    else if (count_step != '0) state_nxt = S_RD_REQ;
                    else state_nxt = S_IDLE;
         S_FLUSH:   if (sweep == LAST_IDX) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // Saturating counter update from the registered table read.
   always_comb begin
      hit = rd_valid && (rd_tag == head_pc);
      if (hit) begin
         if (fifo_taken[head]) ctr_calc = (rd_ctr == 2'b11) ? 2'b11 : rd_ctr + 2'd1;
         else                  ctr_calc = (rd_ctr == 2'b00) ? 2'b00 : rd_ctr - 2'd1;
      end else begin
         ctr_calc = fifo_taken[head] ? 2'b10 : 2'b01;
      end
   end

   // Control state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         starve_cnt <= '0;
         flush_pend <= 1'b0;
         sweep      <= '0;
         ctr_q      <= 2'b00;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values of the others, independent of statement order.
         state <= state_nxt;
         // A request arriving on the entry cycle survives and queues a
         // second sweep.
         flush_pend <= flush_req || (flush_pend && !flush_entry);
         if (flush_entry) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            sweep      <= '0;
            starve_cnt <= '0;
         end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            count <= count_step;
            if (state == S_FLUSH) sweep <= sweep + IDX_W'(1);
            if (upd_win)
               starve_cnt <= '0;
            else if (state == S_RD_REQ && f_req && starve_cnt != STARVE_AT)
               starve_cnt <= starve_cnt + SC_W'(1);
         end
         if (state == S_WAIT_RD) ctr_q <= ctr_calc;
      end
   end

   // NOTE: FIFO storage has no reset; the pointers and count alone decide
   // which slots are live, so resetting the payload would add no information.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc[tail]     <= ex_pc;
         fifo_target[tail] <= ex_target;
         fifo_taken[tail]  <= ex_taken;
      end
   end

   // Read-port arbitration and table write port.
   always_comb begin
      f_grant    = f_req && !upd_win && (state != S_FLUSH);
      f_stall    = f_req && !f_grant;
      rd_en      = upd_win || f_grant;
      rd_idx     = upd_win ? head_pc[IDX_W-1:0] : (f_grant ? f_pc[IDX_W-1:0] : '0);
      wr_en      = 1'b0;
      wr_idx     = '0;
      wr_tag     = '0;
      wr_target  = '0;
      wr_valid   = 1'b0;
      wr_ctr     = 2'b00;
      if (state == S_WRITE) begin
         wr_en     = 1'b1;
         wr_idx    = head_pc[IDX_W-1:0];
         wr_tag    = head_pc;
         wr_target = fifo_target[head];
         wr_valid  = 1'b1;
         wr_ctr    = ctr_q;
      end else if (state == S_FLUSH) begin
         wr_en  = 1'b1;
         wr_idx = sweep;
      end
      flush_busy = (state == S_FLUSH);
      busy       = (state != S_IDLE) || (count != '0);
   end

endmodule

// File: tb/tb_bht_update_scheduler.sv
// -----------------------------------------------------------------------------
// tb_bht_update_scheduler
//
// Self-checking bench. The bench owns a small table model that answers reads
// one cycle after rd_en and absorbs the DUT's writes. Directed sequences cover
// latency, counter saturation, FIFO full, starvation, flush and reset
// mid-sweep. A randomized phase compares every table write against a reference
// that applies the counter rules to a shadow table in push order.
// -----------------------------------------------------------------------------
module tb_bht_update_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic        ex_valid, ex_taken, ex_ready;
   logic [31:0] ex_pc, ex_target;
   logic        f_req, f_grant, f_stall;
   logic [31:0] f_pc;
   logic        rd_en;
   logic [6:0]  rd_idx;
   logic        rd_valid;
   logic [31:0] rd_tag;
   logic [1:0]  rd_ctr;
   logic        wr_en, wr_valid;
   logic [6:0]  wr_idx;
   logic [31:0] wr_tag, wr_target;
   logic [1:0]  wr_ctr;
   logic        flush_req, flush_busy, busy;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // Table contents as seen through the read port, plus a shadow table for
   // the reference model.
   logic        mem_valid [128];
   logic [31:0] mem_tag   [128];
   logic [1:0]  mem_ctr   [128];
   logic        ref_valid [128];
   logic [31:0] ref_tag   [128];
   logic [1:0]  ref_ctr   [128];

   typedef struct {
      logic       mvalid;
      logic       tag_eq;
      logic [1:0] mctr;
      logic       taken;
      logic [1:0] exp_ctr;
   } vec_t;

   typedef struct {
      logic [6:0]  idx;
      logic [31:0] tag;
      logic [31:0] target;
      logic [1:0]  ctr;
   } exp_t;

   bht_update_scheduler dut (
      .clk(clk), .reset(reset),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_target(ex_target),
      .ex_taken(ex_taken), .ex_ready(ex_ready),
      .f_req(f_req), .f_pc(f_pc), .f_grant(f_grant), .f_stall(f_stall),
      .rd_en(rd_en), .rd_idx(rd_idx),
      .rd_valid(rd_valid), .rd_tag(rd_tag), .rd_ctr(rd_ctr),
      .wr_en(wr_en), .wr_idx(wr_idx), .wr_tag(wr_tag), .wr_target(wr_target),
      .wr_valid(wr_valid), .wr_ctr(wr_ctr),
      .flush_req(flush_req), .flush_busy(flush_busy), .busy(busy)
   );

   always #5 clk = ~clk;

   // Registered table read port.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_valid <= 1'b0;
         rd_tag   <= '0;
         rd_ctr   <= 2'b00;
      end else if (rd_en) begin
         rd_valid <= mem_valid[rd_idx];
         rd_tag   <= mem_tag[rd_idx];
         rd_ctr   <= mem_ctr[rd_idx];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      else n_pass++;
   endtask

   // Inputs are driven 1 time unit after a rising edge; outputs are sampled
   // 3 units later, well clear of both clock edges.
   task automatic settle();
      #3;
   endtask

   task automatic advance();
      if (wr_en) begin
         mem_valid[wr_idx] = wr_valid;
         mem_tag[wr_idx]   = wr_tag;
         mem_ctr[wr_idx]   = wr_ctr;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle_inputs();
      ex_valid = 1'b0; ex_pc = '0; ex_target = '0; ex_taken = 1'b0;
      f_req = 1'b0; f_pc = '0; flush_req = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc++;
   endtask

   // One uncontended update: returns read/write latency relative to the push
   // cycle and the fields of the resulting write.
   task automatic single_update(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                                output int rd_lat, output int wr_lat,
                                output logic [6:0] widx, output logic [31:0] wtag,
                                output logic [31:0] wtgt, output logic wval,
                                output logic [1:0] wctr);
      int start;
      rd_lat = -1; wr_lat = -1;
      widx = 'x; wtag = 'x; wtgt = 'x; wval = 1'bx; wctr = 2'bxx;
      ex_valid = 1'b1; ex_pc = pc; ex_target = tgt; ex_taken = tk;
      start = cyc;
      settle();
      check("push_ready", 32'(ex_ready), 32'd1);
      advance();
      ex_valid = 1'b0;
      for (int k = 1; k < 30; k++) begin
         settle();
         if (rd_en && !f_grant && rd_lat < 0) rd_lat = cyc - start;
         if (wr_en && wr_lat < 0) begin
            wr_lat = cyc - start;
            widx = wr_idx; wtag = wr_tag; wtgt = wr_target; wval = wr_valid; wctr = wr_ctr;
         end
         advance();
         if (wr_lat >= 0 && k > wr_lat + 2) break;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       vecs [9];
      exp_t       exp_q [$];
      logic [31:0] wq [$];
      int         rd_lat, wr_lat;
      logic [6:0] widx;
      logic [31:0] wtag, wtgt;
      logic       wval;
      logic [1:0] wctr;

      // valid, tag match, stored ctr, taken, expected ctr
      vecs[0] = '{1'b0, 1'b0, 2'd0, 1'b1, 2'd2};  // miss, taken
      vecs[1] = '{1'b0, 1'b0, 2'd3, 1'b0, 2'd1};  // miss, not taken
      vecs[2] = '{1'b1, 1'b0, 2'd0, 1'b1, 2'd2};  // valid but tag differs
      vecs[3] = '{1'b1, 1'b1, 2'd3, 1'b1, 2'd3};  // saturate high
      vecs[4] = '{1'b1, 1'b1, 2'd0, 1'b0, 2'd0};  // saturate low
      vecs[5] = '{1'b1, 1'b1, 2'd1, 1'b1, 2'd2};
      vecs[6] = '{1'b1, 1'b1, 2'd2, 1'b0, 2'd1};
      vecs[7] = '{1'b1, 1'b1, 2'd1, 1'b0, 2'd0};
      vecs[8] = '{1'b1, 1'b1, 2'd2, 1'b1, 2'd3};

      for (int i = 0; i < 128; i++) begin
         mem_valid[i] = 1'b0; mem_tag[i] = '0; mem_ctr[i] = 2'b00;
      end

      // ---------------- reset state ----------------
      reset = 1'b1;
      idle_inputs();
      #3;
      check("rst_ex_ready", 32'(ex_ready), 32'd1);
      check("rst_outputs", {24'd0, f_grant, f_stall, rd_en, wr_en, wr_valid, flush_busy, busy, 1'b0}, 32'd0);
      check("rst_idx_ctr", {16'd0, 1'b0, rd_idx, 1'b0, wr_idx}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // ---------------- miss: latency and write fields ----------------
      do_reset();
      single_update(32'h40, 32'h100, 1'b1, rd_lat, wr_lat, widx, wtag, wtgt, wval, wctr);
      check("miss_rd_latency", 32'(rd_lat), 32'd2);
      check("miss_wr_latency", 32'(wr_lat), 32'd4);
      check("miss_wr_idx",    32'(widx), 32'h40);
      check("miss_wr_tag",    wtag, 32'h40);
      check("miss_wr_target", wtgt, 32'h100);
      check("miss_wr_valid",  32'(wval), 32'd1);
      check("miss_wr_ctr",    32'(wctr), 32'd2);

      // ---------------- counter rules, table driven ----------------
      for (int i = 0; i < 9; i++) begin
         logic [31:0] pc;
         pc = 32'h0000_0a00 + 32'(i * 8);
         mem_valid[pc[6:0]] = vecs[i].mvalid;
         mem_tag[pc[6:0]]   = vecs[i].tag_eq ? pc : (pc ^ 32'h8000);
         mem_ctr[pc[6:0]]   = vecs[i].mctr;
         single_update(pc, pc + 32'h40, vecs[i].taken, rd_lat, wr_lat, widx, wtag, wtgt, wval, wctr);
         check($sformatf("vec%0d_ctr", i), 32'(wctr), 32'(vecs[i].exp_ctr));
      end

      // ---------------- FIFO full under fetch pressure ----------------
      begin
         int first_wr, acc;
         do_reset();
         f_req = 1'b1; f_pc = 32'h7f;
         for (int i = 0; i < 4; i++) begin
            ex_valid = 1'b1; ex_pc = 32'h300 + 32'(i * 4); ex_target = 32'h900; ex_taken = 1'b1;
            settle();
            check($sformatf("fill_ready%0d", i), 32'(ex_ready), 32'd1);
            advance();
         end
         ex_pc = 32'h310;
         first_wr = -1; acc = -1;
         wq.delete();
         settle();
         check("full_blocks_5th", 32'(ex_ready), 32'd0);
         advance();
         for (int k = 0; k < 60 && acc < 0; k++) begin
            settle();
            if (wr_en) begin
               wq.push_back(wr_tag);
               if (first_wr < 0) first_wr = cyc;
            end
            if (ex_ready) acc = cyc;
            advance();
         end
         ex_valid = 1'b0;
         check("full_accept_after_pop", 32'(acc - first_wr), 32'd1);
         f_req = 1'b0;
         for (int k = 0; k < 60; k++) begin
            settle();
            if (wr_en) wq.push_back(wr_tag);
            advance();
         end
         check("full_write_count", 32'(wq.size()), 32'd5);
         for (int i = 0; i < 5; i++)
            check($sformatf("full_order%0d", i), (i < wq.size()) ? wq[i] : 32'hdead_beef, 32'h300 + 32'(i * 4));
      end

      // ---------------- starvation guard ----------------
      begin
         int grants;
         do_reset();
         f_req = 1'b1; f_pc = 32'h05;
         ex_valid = 1'b1; ex_pc = 32'h2a4; ex_target = 32'h10; ex_taken = 1'b0;
         settle();
         advance();
         ex_valid = 1'b0;
         grants = 0;
         for (int k = 1; k <= 10; k++) begin
            settle();
            if (k == 1) check("starve_idle_grant", 32'(f_grant), 32'd1);
            if (k >= 2 && k <= 9 && f_grant && rd_idx == 7'h05) grants++;
            if (k == 10) begin
               check("starve_win_flags", {29'd0, f_grant, f_stall, rd_en}, 32'b011);
               check("starve_win_idx", 32'(rd_idx), 32'h24);
            end
            advance();
         end
         check("starve_grant_cycles", 32'(grants), 32'd8);
         f_req = 1'b0;
         for (int k = 0; k < 10; k++) begin settle(); advance(); end
      end

      // ---------------- flush sweep ----------------
      begin
         int sweeps, bad_wr, bad_rdy, bad_gnt, stray, idle_chk;
         do_reset();
         f_req = 1'b1; f_pc = 32'h11;
         for (int i = 0; i < 2; i++) begin
            ex_valid = 1'b1; ex_pc = 32'h500 + 32'(i * 4); ex_target = 32'h1; ex_taken = 1'b1;
            settle();
            advance();
         end
         ex_valid = 1'b0;
         flush_req = 1'b1;
         settle();
         advance();
         flush_req = 1'b0;
         sweeps = 0; bad_wr = 0; bad_rdy = 0; bad_gnt = 0; stray = 0; idle_chk = 0;
         for (int c = 0; c < 170; c++) begin
            settle();
            if (flush_busy) begin
               if (!(wr_en && wr_idx == 7'(sweeps) && !wr_valid && wr_tag == 0 &&
                     wr_target == 0 && wr_ctr == 0)) bad_wr++;
               if (ex_ready) bad_rdy++;
               if (f_grant || rd_en) bad_gnt++;
               sweeps++;
            end else if (sweeps > 0) begin
               if (wr_en) stray++;
               if (idle_chk == 0) begin
                  check("flush_busy_after", 32'(busy), 32'd0);
                  idle_chk = 1;
               end
            end
            advance();
         end
         check("flush_cycles", 32'(sweeps), 32'd128);
         check("flush_write_fields", 32'(bad_wr), 32'd0);
         check("flush_ex_ready_low", 32'(bad_rdy), 32'd0);
         check("flush_no_grant", 32'(bad_gnt), 32'd0);
         check("flush_queued_dropped", 32'(stray), 32'd0);
         f_req = 1'b0;
      end

      // ---------------- reset in the middle of a sweep ----------------
      begin
         int reached, stray;
         do_reset();
         flush_req = 1'b1;
         settle();
         advance();
         flush_req = 1'b0;
         reached = 0;
         for (int c = 0; c < 80; c++) begin
            settle();
            if (flush_busy && wr_idx == 7'd50) begin
               reset = 1'b1;
               #1;
               check("rst_mid_outputs", {26'd0, wr_en, flush_busy, busy, rd_en, f_grant, f_stall}, 32'd0);
               check("rst_mid_ex_ready", 32'(ex_ready), 32'd1);
               @(posedge clk);
               @(posedge clk);
               #1;
               reset = 1'b0;
               cyc += 2;
               reached = 1;
               break;
            end
            advance();
         end
         check("rst_mid_reached", 32'(reached), 32'd1);
         stray = 0;
         for (int c = 0; c < 20; c++) begin
            settle();
            if (wr_en || busy) stray++;
            advance();
         end
         check("rst_mid_quiet", 32'(stray), 32'd0);
      end

      // ---------------- randomized against reference model ----------------
      begin
         int cnt, n_cons, n_rdy;
         do_reset();
         for (int i = 0; i < 8; i++) begin
            mem_valid[i] = 1'($urandom_range(0, 1));
            mem_tag[i]   = ($urandom_range(0, 1) != 0 ? 32'h1000 : 32'h2000) | 32'(i);
            mem_ctr[i]   = 2'($urandom_range(0, 3));
            ref_valid[i] = mem_valid[i];
            ref_tag[i]   = mem_tag[i];
            ref_ctr[i]   = mem_ctr[i];
         end
         exp_q.delete();
         cnt = 0; n_cons = 0; n_rdy = 0;
         for (int c = 0; c < 800; c++) begin
            ex_valid  = (c < 700) && ($urandom_range(0, 99) < 45);
            ex_pc     = ($urandom_range(0, 1) != 0 ? 32'h1000 : 32'h2000) | 32'($urandom_range(0, 7));
            ex_target = $urandom;
            ex_taken  = 1'($urandom_range(0, 1));
            f_req     = (c < 700) && ($urandom_range(0, 99) < 60);
            f_pc      = $urandom;
            settle();
            if (ex_ready != (cnt < 4)) n_rdy++;
            if (f_stall != (f_req && !f_grant)) n_cons++;
            if (!f_req && f_grant) n_cons++;
            if (f_grant && !(rd_en && rd_idx == f_pc[6:0])) n_cons++;
            if (wr_en) begin
               if (exp_q.size() == 0) begin
                  check("rnd_unexpected_write", 32'(wr_idx), 32'hffff_ffff);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  check("rnd_wr_idx", 32'(wr_idx), 32'(e.idx));
                  check("rnd_wr_tag", wr_tag, e.tag);
                  check("rnd_wr_target", wr_target, e.target);
                  check("rnd_wr_ctr", 32'(wr_ctr), 32'(e.ctr));
               end
               cnt--;
            end
            if (ex_valid && ex_ready) begin
               exp_t e;
               int   old_c, new_c;
               e.idx    = ex_pc[6:0];
               e.tag    = ex_pc;
               e.target = ex_target;
               old_c    = int'(ref_ctr[e.idx]);
               if (ref_valid[e.idx] && ref_tag[e.idx] == ex_pc)
                  new_c = ex_taken ? ((old_c + 1 > 3) ? 3 : old_c + 1) : ((old_c - 1 < 0) ? 0 : old_c - 1);
               else
                  new_c = ex_taken ? 2 : 1;
               e.ctr = 2'(new_c);
               ref_valid[e.idx] = 1'b1;
               ref_tag[e.idx]   = ex_pc;
               ref_ctr[e.idx]   = e.ctr;
               exp_q.push_back(e);
               cnt++;
            end
            advance();
         end
         check("rnd_ex_ready_vs_count", 32'(n_rdy), 32'd0);
         check("rnd_fetch_arbitration", 32'(n_cons), 32'd0);
         check("rnd_all_written", 32'(exp_q.size()), 32'd0);
         settle();
         check("rnd_drained_idle", 32'(busy), 32'd0);
         advance();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
